// File: rtl/pushbutton_conditioner.sv
// pushbutton_conditioner
//   Input front-end for the 4-bit uP. Each of the four raw button pads is
//   synchronized into the clock domain, debounced by a per-channel counter
//   and state machine, and presented as a clean level. One-cycle press and
//   release pulses are produced for debug LEDs and future interrupt logic.
//
//   Optional feature (macro PUSHBUTTON_STICKY_EN): pushbuttons carries a
//   sticky press latch per bit, set by press_pulse and cleared by
//   clear_latch. Set wins over a same-cycle clear.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   raw_buttons    asynchronous button pads, active-high when pressed
//   sample_en      debounce sampling tick (tie high for per-clock sampling)
//   clear_latch    per-bit clear of the sticky latch (sticky build only)
//   pushbuttons    conditioned button value to the uP
//   press_pulse    one-cycle pulse on an accepted 0->1 transition
//   release_pulse  one-cycle pulse on an accepted 1->0 transition
//   any_pressed    OR of the four debounced levels
module pushbutton_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] raw_buttons,
    input  logic       sample_en,
    input  logic [3:0] clear_latch,
    output logic [3:0] pushbuttons,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic       any_pressed
);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] DEB = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q [4];
    logic [3:0]             sync;
    state_t                 state_q [4];
    state_t                 state_d [4];
    logic [CNT_W-1:0]       cnt_q [4];
    logic [CNT_W-1:0]       cnt_d [4];
    logic [3:0]             level_q;
    logic [3:0]             press_evt;
    logic [3:0]             release_evt;

    // Synchronizer chains run every clock, independent of sample_en.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) sync_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_buttons[i]};
        end
    end

    always_comb begin
        sync = '0;
        for (int unsigned i = 0; i < 4; i++) sync[i] = sync_q[i][SYNC_STAGES-1];
    end

    // State register, debounce counters, levels and registered pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= STABLE_LOW;
                cnt_q[i]   <= '0;
            end
            level_q       <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            level_q       <= (level_q | press_evt) & ~release_evt;
            press_pulse   <= press_evt;
            release_pulse <= release_evt;
        end
    end

    // Output decode: an event fires on the tick that completes the count.
    // With a single-tick debounce the stable state accepts immediately.
    always_comb begin
        press_evt   = '0;
        release_evt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sample_en && sync[i]) begin
                if ((state_q[i] == STABLE_LOW && DEB == ONE) ||
                    (state_q[i] == WAIT_HIGH && (cnt_q[i] + ONE) == DEB))
                    press_evt[i] = 1'b1;
            end
            if (sample_en && !sync[i]) begin
                if ((state_q[i] == STABLE_HIGH && DEB == ONE) ||
                    (state_q[i] == WAIT_LOW && (cnt_q[i] + ONE) == DEB))
                    release_evt[i] = 1'b1;
            end
        end
    end

    // Next-state logic; without a sample tick everything holds.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (sample_en) begin
                unique case (state_q[i])
                    STABLE_LOW: begin
                        if (sync[i]) begin
                            if (press_evt[i]) begin
                                state_d[i] = STABLE_HIGH;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = WAIT_HIGH;
                                cnt_d[i]   = ONE;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync[i]) begin
                            state_d[i] = STABLE_LOW;
                            cnt_d[i]   = '0;
                        end else if (press_evt[i]) begin
                            state_d[i] = STABLE_HIGH;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE;
                        end
                    end
                    STABLE_HIGH: begin
                        if (!sync[i]) begin
                            if (release_evt[i]) begin
                                state_d[i] = STABLE_LOW;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = WAIT_LOW;
                                cnt_d[i]   = ONE;
                            end
                        end
                    end
                    WAIT_LOW: begin
                        if (sync[i]) begin
                            state_d[i] = STABLE_HIGH;
                            cnt_d[i]   = '0;
                        end else if (release_evt[i]) begin
                            state_d[i] = STABLE_LOW;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE;
                        end
                    end
                    default: begin
                        state_d[i] = STABLE_LOW;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    assign any_pressed = |level_q;

`ifdef PUSHBUTTON_STICKY_EN
    logic [3:0] latch_q;

    // Set has priority over clear so a press is never lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) latch_q <= '0;
        else       latch_q <= (latch_q & ~clear_latch) | press_pulse;
    end

    assign pushbuttons = latch_q;
`else
    logic unused_clear;
    assign unused_clear = |clear_latch;
    assign pushbuttons  = level_q;
`endif

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed testbench for pushbutton_conditioner (DEBOUNCE_CYCLES=4, plus a
// DEBOUNCE_CYCLES=1 instance for the immediate-accept path). Edge numbers in
// comments count rising edges after an input change, starting at 1.
module tb_pushbutton_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] raw_buttons = '0;
    logic [3:0] clear_latch = '0;
    logic       slow_mode = 1'b0;
    logic [2:0] div = '0;
    logic       sample_en;

    logic [3:0] pushbuttons, press_pulse, release_pulse;
    logic       any_pressed;
    logic [3:0] pushbuttons1, press_pulse1, release_pulse1;
    logic       any_pressed1;

    int checks = 0;
    int errors = 0;

    logic se_now, hit;
    int   ticks;
    bit   done;

    always #5 clock = ~clock;

    // Prescaler: one sample tick in eight while slow_mode is set.
    always @(posedge clock) div <= div + 3'd1;
    assign sample_en = slow_mode ? (div == 3'd0) : 1'b1;

    pushbutton_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5),
        .SYNC_STAGES(2)
    ) u_dut (
        .clock(clock),
        .reset(reset),
        .raw_buttons(raw_buttons),
        .sample_en(sample_en),
        .clear_latch(clear_latch),
        .pushbuttons(pushbuttons),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .any_pressed(any_pressed)
    );

    pushbutton_conditioner #(
        .DEBOUNCE_CYCLES(1),
        .CNT_W(5),
        .SYNC_STAGES(2)
    ) u_dut1 (
        .clock(clock),
        .reset(reset),
        .raw_buttons(raw_buttons),
        .sample_en(sample_en),
        .clear_latch(clear_latch),
        .pushbuttons(pushbuttons1),
        .press_pulse(press_pulse1),
        .release_pulse(release_pulse1),
        .any_pressed(any_pressed1)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // Reset held with all buttons pressed: everything stays 0.
        reset = 1'b1;
        raw_buttons = 4'hF;
        tick(3);
        check("rst_pb", pushbuttons, 4'h0);
        check("rst_press", press_pulse, 4'h0);
        check("rst_release", release_pulse, 4'h0);
        check("rst_any", {3'b000, any_pressed}, 4'h0);
        check("rst_pb_d1", pushbuttons1, 4'h0);

`ifndef PUSHBUTTON_STICKY_EN
        // Test 1: release reset with pads held; accept at edge 2+4.
        reset = 1'b0;
        tick(2);
        check("t1_d1_press_e2", press_pulse1, 4'h0);
        tick(1);
        check("t1_d1_press_e3", press_pulse1, 4'hF);
        check("t1_d1_pb_e3", pushbuttons1, 4'hF);
        tick(1);
        check("t1_d1_press_e4", press_pulse1, 4'h0);
        tick(1);
        check("t1_press_e5", press_pulse, 4'h0);
        check("t1_pb_e5", pushbuttons, 4'h0);
        tick(1);
        check("t1_press_e6", press_pulse, 4'hF);
        check("t1_pb_e6", pushbuttons, 4'hF);
        check("t1_release_e6", release_pulse, 4'h0);
        tick(1);
        check("t1_press_e7", press_pulse, 4'h0);
        check("t1_pb_e7", pushbuttons, 4'hF);

        // Release all buttons.
        raw_buttons = 4'h0;
        tick(5);
        check("rel_e5", release_pulse, 4'h0);
        tick(1);
        check("rel_e6", release_pulse, 4'hF);
        check("rel_press_e6", press_pulse, 4'h0);
        tick(1);
        check("rel_e7", release_pulse, 4'h0);
        check("rel_pb", pushbuttons, 4'h0);
        check("rel_any", {3'b000, any_pressed}, 4'h0);

        // Test 2: bit 0 press accepted at edge 6 for exactly one cycle.
        raw_buttons = 4'b0001;
        tick(5);
        check("t2_pb_e5", pushbuttons, 4'b0000);
        check("t2_press_e5", press_pulse, 4'b0000);
        tick(1);
        check("t2_pb_e6", pushbuttons, 4'b0001);
        check("t2_press_e6", press_pulse, 4'b0001);
        check("t2_any_e6", {3'b000, any_pressed}, 4'b0001);
        tick(1);
        check("t2_press_e7", press_pulse, 4'b0000);
        check("t2_pb_e7", pushbuttons, 4'b0001);

        // Test 3: bit 1 high for 3 cycles only -> count reaches 3, rejected.
        raw_buttons = 4'b0011;
        tick(3);
        raw_buttons = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            check("t3_press", press_pulse, 4'b0000);
            check("t3_release", release_pulse, 4'b0000);
            check("t3_pb", pushbuttons, 4'b0001);
        end

        // Test 4 setup: bit 2 pressed at full rate.
        raw_buttons = 4'b0101;
        tick(7);
        check("t4_setup_pb", pushbuttons, 4'b0101);

        // Test 4: slow ticks, bit 2 released. FSM first sees the new value
        // at edge 3; the release lands on the 4th tick from there on.
        slow_mode = 1'b1;
        raw_buttons = 4'b0001;
        ticks = 0;
        done = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            se_now = sample_en;
            hit = 1'b0;
            if (k >= 3 && se_now) begin
                ticks++;
                hit = (ticks == 4);
            end
            tick(1);
            check("t4_release", release_pulse, hit ? 4'b0100 : 4'b0000);
            check("t4_pb", pushbuttons, hit ? 4'b0001 : 4'b0101);
            if (hit) done = 1'b1;
        end
        slow_mode = 1'b0;
        tick(1);
        check("t4_release_after", release_pulse, 4'b0000);

        // Test 5: reset mid-debounce on bit 3 (cnt=3 after edge 5).
        raw_buttons = 4'b1001;
        tick(5);
        check("t5_press_pre", press_pulse, 4'b0000);
        reset = 1'b1;
        tick(1);
        check("t5_rst_pb", pushbuttons, 4'b0000);
        check("t5_rst_any", {3'b000, any_pressed}, 4'b0000);
        check("t5_rst_release", release_pulse, 4'b0000);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("t5_press_e5", press_pulse, 4'b0000);
        check("t5_release_e5", release_pulse, 4'b0000);
        tick(1);
        check("t5_press_e6", press_pulse, 4'b1001);
        check("t5_pb_e6", pushbuttons, 4'b1001);
        tick(1);
        check("t5_press_e7", press_pulse, 4'b0000);
`else
        // Test 6: sticky latch behaviour on bit 0.
        raw_buttons = 4'h0;
        tick(2);
        reset = 1'b0;
        tick(2);
        raw_buttons = 4'b0001;
        tick(6);
        check("t6_press_e6", press_pulse, 4'b0001);
        check("t6_pb_e6", pushbuttons, 4'b0000);
        tick(1);
        check("t6_pb_set", pushbuttons, 4'b0001);
        raw_buttons = 4'b0000;
        tick(7);
        check("t6_pb_after_release", pushbuttons, 4'b0001);
        clear_latch = 4'b0001;
        tick(1);
        clear_latch = 4'b0000;
        check("t6_pb_cleared", pushbuttons, 4'b0000);
        raw_buttons = 4'b0001;
        tick(5);
        clear_latch = 4'b0001;
        tick(1);
        check("t6_press_with_clear", press_pulse, 4'b0001);
        tick(1);
        check("t6_set_wins", pushbuttons, 4'b0001);
        clear_latch = 4'b0000;
        tick(1);
        check("t6_pb_hold", pushbuttons, 4'b0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
